// File: rtl/irq_service_sequencer_if.sv
// CPU-side bundle for irq_service_sequencer: interrupt lines, config writes,
// and the request/ack/vector/eoi handshake.
interface irq_service_sequencer_if #(
   parameter int N_IRQ  = 4,
   parameter int PRIO_W = 2,
   parameter int VEC_W  = 8
);
   logic [N_IRQ-1:0]        irq_in;
   logic                    mask_wr;
   logic [N_IRQ-1:0]        mask_data;
   logic                    prio_wr;
   logic [N_IRQ*PRIO_W-1:0] prio_data;
   logic                    int_ack;
   logic                    eoi;
   logic                    int_req;
   logic [VEC_W-1:0]        vec_out;
   logic                    vec_valid;
   logic [N_IRQ-1:0]        in_service;
   logic [N_IRQ-1:0]        pending;

   // Handshake: int_req stays high until a one-cycle int_ack. Acks land on the
   // current winner, and vec_valid pulses the following cycle. The source then
   // stays in service until a one-cycle eoi. Stray ack/eoi pulses are ignored.
   modport master (
      output irq_in, mask_wr, mask_data, prio_wr, prio_data, int_ack, eoi,
      input  int_req, vec_out, vec_valid, in_service, pending
   );
   modport slave (
      input  irq_in, mask_wr, mask_data, prio_wr, prio_data, int_ack, eoi,
      output int_req, vec_out, vec_valid, in_service, pending
   );
endinterface

// File: rtl/irq_service_sequencer.sv
// Vectored interrupt sequencer: edge-latched, masked, priority-arbitrated requests.
// Optional macro IRQ_ACK_TIMEOUT_EN abandons an unacknowledged request after ACK_TIMEOUT cycles.
module irq_service_sequencer #(
   parameter int                N_IRQ       = 4,
   parameter int                PRIO_W      = 2,
   parameter int                VEC_W       = 8,
`ifdef IRQ_ACK_TIMEOUT_EN
   parameter int                ACK_TIMEOUT = 16,
`endif
   parameter logic [VEC_W-1:0]  VEC_BASE    = 'h40
) (
   input  logic                           clk,
   input  logic                           rst,
   irq_service_sequencer_if.slave         bus,
   output logic [1:0]                     o_dbg_state
);
   localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_VEC     = 2'd2,
      S_SERVICE = 2'd3
   } state_t;

   state_t                  r_state, w_next_state;
   logic [N_IRQ-1:0]        r_irq_d, r_pending, r_mask, r_in_service;
   logic [N_IRQ*PRIO_W-1:0] r_prio;
   logic [VEC_W-1:0]        r_vec_out;
   logic                    r_vec_valid, r_int_req;

   logic [N_IRQ-1:0]        w_eligible, w_rise, w_clr, w_win_onehot;
   logic [IDX_W-1:0]        w_winner;
   logic [PRIO_W-1:0]       w_best_prio;
   logic                    w_found, w_ack_fire, w_timeout;

   function automatic logic [N_IRQ*PRIO_W-1:0] default_prio();
      logic [N_IRQ*PRIO_W-1:0] p;
      p = '0;
      for (int i = 0; i < N_IRQ; i++) p[i*PRIO_W +: PRIO_W] = PRIO_W'(i);
      return p;
   endfunction

   assign w_eligible = r_pending & ~r_mask;
   assign w_rise     = bus.irq_in & ~r_irq_d;

   // Ascending scan with strict '>' leaves ties with the lowest index.
   always_comb begin
      w_found     = 1'b0;
      w_best_prio = '0;
      w_winner    = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (w_eligible[i] && (!w_found || (r_prio[i*PRIO_W +: PRIO_W] > w_best_prio))) begin
            w_found     = 1'b1;
            w_best_prio = r_prio[i*PRIO_W +: PRIO_W];
            w_winner    = IDX_W'(i);
         end
      end
   end

   assign w_win_onehot = N_IRQ'(1) << w_winner;
   assign w_ack_fire   = (r_state == S_REQ) && bus.int_ack && w_found;
   assign w_clr        = w_ack_fire ? w_win_onehot : '0;

`ifdef IRQ_ACK_TIMEOUT_EN
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   logic [CNT_W-1:0] r_to_cnt;

   always_ff @(posedge clk) begin
      if (rst || (r_state != S_REQ)) r_to_cnt <= '0;
      else                           r_to_cnt <= r_to_cnt + 1'b1;
   end

   // Counter holds the number of REQ cycles already spent, so REQ lasts ACK_TIMEOUT cycles.
   assign w_timeout = (r_state == S_REQ) && (r_to_cnt == CNT_W'(ACK_TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (|w_eligible) w_next_state = S_REQ;
         S_REQ: begin
            if (w_ack_fire)        w_next_state = S_VEC;
            else if (!w_found)     w_next_state = S_IDLE;
            else if (w_timeout)    w_next_state = S_IDLE;
         end
         S_VEC:     w_next_state = S_SERVICE;
         S_SERVICE: if (bus.eoi) w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_irq_d      <= '0;
         r_pending    <= '0;
         r_mask       <= '0;
         r_prio       <= default_prio();
         r_in_service <= '0;
         r_vec_out    <= '0;
         r_vec_valid  <= 1'b0;
         r_int_req    <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_irq_d     <= bus.irq_in;
         r_pending   <= (r_pending & ~w_clr) | w_rise;
         r_int_req   <= (w_next_state == S_REQ);
         r_vec_valid <= (w_next_state == S_VEC);
         if (bus.mask_wr) r_mask <= bus.mask_data;
         if (bus.prio_wr) r_prio <= bus.prio_data;
         if (w_ack_fire) begin
            r_in_service <= w_win_onehot;
            r_vec_out    <= VEC_BASE + VEC_W'(w_winner);
         end else if ((r_state == S_SERVICE) && bus.eoi) begin
            r_in_service <= '0;
         end
      end
   end

   assign bus.int_req    = r_int_req;
   assign bus.vec_out    = r_vec_out;
   assign bus.vec_valid  = r_vec_valid;
   assign bus.in_service = r_in_service;
   assign bus.pending    = r_pending;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_irq_service_sequencer.sv
// Directed bench for irq_service_sequencer; build with +define+IRQ_ACK_TIMEOUT_EN to cover the timeout.
module tb_irq_service_sequencer;
   localparam int N = 4;
   localparam int P = 2;
   localparam int V = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;
   int         n_checks = 0;
   int         n_fail   = 0;

   irq_service_sequencer_if #(.N_IRQ(N), .PRIO_W(P), .VEC_W(V)) bus();

   irq_service_sequencer #(.N_IRQ(N), .PRIO_W(P), .VEC_W(V), .VEC_BASE(8'h40)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_quiet();
      bus.irq_in    = '0;
      bus.mask_wr   = 1'b0;
      bus.mask_data = '0;
      bus.prio_wr   = 1'b0;
      bus.prio_data = '0;
      bus.int_ack   = 1'b0;
      bus.eoi       = 1'b0;
   endtask

   task automatic pulse_irq(input logic [N-1:0] lines);
      bus.irq_in = lines;
      tick();
      bus.irq_in = '0;
   endtask

   task automatic write_prio(input logic [N*P-1:0] p);
      bus.prio_wr = 1'b1; bus.prio_data = p;
      tick();
      bus.prio_wr = 1'b0;
   endtask

   task automatic write_mask(input logic [N-1:0] m);
      bus.mask_wr = 1'b1; bus.mask_data = m;
      tick();
      bus.mask_wr = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.int_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // One full ack/eoi round for whichever source currently wins.
   task automatic do_round(input logic [7:0] exp_vec, input string name);
      bit ok;
      wait_req(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s int_req: timed out waiting, required 1", name);
      end
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      n_checks++;
      if (bus.vec_valid !== 1'b1 || bus.vec_out !== exp_vec) begin
         n_fail++;
         $display("FAIL %s vector: got valid=%b vec=%h, required valid=1 vec=%h",
                  name, bus.vec_valid, bus.vec_out, exp_vec);
      end
      n_checks++;
      if (bus.in_service !== (4'b0001 << (exp_vec - 8'h40))) begin
         n_fail++;
         $display("FAIL %s in_service: got %b, required %b", name, bus.in_service,
                  4'b0001 << (exp_vec - 8'h40));
      end
      tick();
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
      n_checks++;
      if (bus.in_service !== 4'b0000 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL %s eoi: got in_service=%b state=%0d, required 0000 / 0",
                  name, bus.in_service, dbg_state);
      end
   endtask

   task automatic test_reset();
      drive_quiet();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({bus.int_req, bus.vec_valid, bus.vec_out, bus.in_service, bus.pending, dbg_state} !== '0) begin
         n_fail++;
         $display("FAIL reset: got req=%b vv=%b vec=%h isv=%b pend=%b st=%0d, required all 0",
                  bus.int_req, bus.vec_valid, bus.vec_out, bus.in_service, bus.pending, dbg_state);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      pulse_irq(4'b0001);
      n_checks++;
      if (bus.pending !== 4'b0001 || bus.int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL basic latch: got pend=%b req=%b, required 0001 / 0", bus.pending, bus.int_req);
      end
      tick();
      n_checks++;
      if (bus.int_req !== 1'b1 || dbg_state !== 2'd1) begin
         n_fail++;
         $display("FAIL basic req: got req=%b st=%0d, required 1 / 1", bus.int_req, dbg_state);
      end
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      n_checks++;
      if (bus.vec_valid !== 1'b1 || bus.vec_out !== 8'h40 || bus.in_service !== 4'b0001 ||
          bus.pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL basic ack: got vv=%b vec=%h isv=%b pend=%b, required 1 40 0001 0000",
                  bus.vec_valid, bus.vec_out, bus.in_service, bus.pending);
      end
      tick();
      n_checks++;
      if (bus.vec_valid !== 1'b0 || dbg_state !== 2'd3 || bus.int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL basic service: got vv=%b st=%0d req=%b, required 0 3 0",
                  bus.vec_valid, dbg_state, bus.int_req);
      end
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
      n_checks++;
      if (bus.in_service !== 4'b0000 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL basic eoi: got isv=%b st=%0d, required 0000 / 0", bus.in_service, dbg_state);
      end
   endtask

   task automatic test_priority();
      logic [7:0] exp_vecs [4] = '{8'h40, 8'h41, 8'h42, 8'h43};
      write_prio(8'b00_01_10_11);
      pulse_irq(4'b1111);
      for (int r = 0; r < 4; r++) do_round(exp_vecs[r], $sformatf("prio_round%0d", r));
   endtask

   task automatic test_tie();
      write_prio(8'b00_00_00_00);
      pulse_irq(4'b0110);
      do_round(8'h41, "tie_first");
      do_round(8'h42, "tie_second");
   endtask

   task automatic test_preempt();
      bit ok;
      write_prio(8'b11_10_01_00);
      pulse_irq(4'b0010);
      wait_req(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL preempt req: timed out waiting, required int_req=1");
      end
      pulse_irq(4'b1000);
      tick();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      n_checks++;
      if (bus.vec_out !== 8'h43 || bus.pending !== 4'b0010) begin
         n_fail++;
         $display("FAIL preempt ack: got vec=%h pend=%b, required 43 / 0010", bus.vec_out, bus.pending);
      end
      tick();
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
      do_round(8'h41, "preempt_leftover");
   endtask

   task automatic test_mask();
      write_mask(4'b0100);
      pulse_irq(4'b0100);
      tick();
      tick();
      n_checks++;
      if (bus.pending !== 4'b0100 || bus.int_req !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL mask hold: got pend=%b req=%b st=%0d, required 0100 0 0",
                  bus.pending, bus.int_req, dbg_state);
      end
      write_mask(4'b0000);
      n_checks++;
      if (bus.int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL mask write latency: got req=%b, required 0", bus.int_req);
      end
      tick();
      n_checks++;
      if (bus.int_req !== 1'b1) begin
         n_fail++;
         $display("FAIL mask release: got req=%b, required 1", bus.int_req);
      end
      do_round(8'h42, "mask_round");
   endtask

   task automatic test_stray();
      bus.int_ack = 1'b1;
      bus.eoi     = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      bus.eoi     = 1'b0;
      tick();
      n_checks++;
      if (dbg_state !== 2'd0 || bus.vec_valid !== 1'b0 || bus.vec_out !== 8'h42 ||
          bus.in_service !== 4'b0000) begin
         n_fail++;
         $display("FAIL stray: got st=%0d vv=%b vec=%h isv=%b, required 0 0 42 0000",
                  dbg_state, bus.vec_valid, bus.vec_out, bus.in_service);
      end
   endtask

   task automatic test_reset_mid_service();
      bit ok;
      pulse_irq(4'b0001);
      wait_req(ok);
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      tick();
      n_checks++;
      if (!ok || dbg_state !== 2'd3) begin
         n_fail++;
         $display("FAIL midrst setup: got req_seen=%b st=%0d, required 1 / 3", ok, dbg_state);
      end
      bus.irq_in = 4'b1000;
      rst = 1'b1;
      tick();
      n_checks++;
      if ({bus.int_req, bus.vec_valid, bus.vec_out, bus.in_service, bus.pending, dbg_state} !== '0) begin
         n_fail++;
         $display("FAIL midrst values: got req=%b vv=%b vec=%h isv=%b pend=%b st=%0d, required all 0",
                  bus.int_req, bus.vec_valid, bus.vec_out, bus.in_service, bus.pending, dbg_state);
      end
      rst = 1'b0;
      tick();
      bus.irq_in = 4'b0000;
      n_checks++;
      if (bus.pending !== 4'b1000) begin
         n_fail++;
         $display("FAIL midrst held line: got pend=%b, required 1000", bus.pending);
      end
      do_round(8'h43, "midrst_round");
   endtask

`ifdef IRQ_ACK_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int drops;
      drops = 0;
      pulse_irq(4'b0010);
      wait_req(ok);
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.int_req !== 1'b1) drops++;
      end
      n_checks++;
      if (!ok || drops != 0) begin
         n_fail++;
         $display("FAIL timeout hold: got req_seen=%b early_drops=%0d, required 1 / 0", ok, drops);
      end
      tick();
      n_checks++;
      if (bus.int_req !== 1'b0 || bus.pending !== 4'b0010) begin
         n_fail++;
         $display("FAIL timeout drop: got req=%b pend=%b, required 0 / 0010", bus.int_req, bus.pending);
      end
      tick();
      n_checks++;
      if (bus.int_req !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout reassert: got req=%b, required 1", bus.int_req);
      end
      do_round(8'h41, "timeout_round");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_tie();
      test_preempt();
      test_mask();
      test_stray();
      test_reset_mid_service();
`ifdef IRQ_ACK_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
